// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: stall/flush/redirect controller for the 5-stage pipeline; PIPE_CTRL_PERF_CNT_EN adds stall/flush counters.
module pipe_ctrl_unit #(
  parameter int XLEN       = 32,
  parameter int PERF_CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hazard_detected,
  input  logic            ex_redirect_valid,
  input  logic [XLEN-1:0] ex_redirect_pc,
  input  logic            ifu_resp_valid,
  input  logic            lsu_req,
  input  logic            lsu_resp_valid,
  output logic            pc_enable,
  output logic            pc_sel_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            if_id_enable,
  output logic            if_id_flush,
  output logic            id_exe_enable,
  output logic            id_exe_flush,
  output logic            exe_mem_enable,
  output logic            mem_wb_enable,
  output logic            mem_wb_bubble
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cycles,
  output logic [PERF_CNT_W-1:0] perf_flush_cnt
`endif
);
  typedef enum logic {RUN, REDIR_WAIT} st_e;
  st_e             st_q, st_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            mem_busy, stall_evt, flush_evt;
  if (XLEN < 1 || PERF_CNT_W < 1) begin : g_bad_param
    $error("pipe_ctrl_unit: widths must be positive");
  end
  assign mem_busy = lsu_req & ~lsu_resp_valid;
  always_comb begin
    pc_enable       = 1'b1;
    pc_sel_redirect = 1'b0;
    redirect_pc     = (st_q == REDIR_WAIT) ? redir_pc_q : ex_redirect_pc;
    if_id_enable    = 1'b1;
    if_id_flush     = 1'b0;
    id_exe_enable   = 1'b1;
    id_exe_flush    = 1'b0;
    exe_mem_enable  = 1'b1;
    mem_wb_enable   = 1'b1;
    mem_wb_bubble   = 1'b0;
    st_d            = st_q;
    redir_pc_d      = redir_pc_q;
    stall_evt       = 1'b0;
    flush_evt       = 1'b0;
    if (rst) begin
      pc_enable      = 1'b0;
      redirect_pc    = '0;
      if_id_enable   = 1'b0;
      if_id_flush    = 1'b1;
      id_exe_enable  = 1'b0;
      id_exe_flush   = 1'b1;
      exe_mem_enable = 1'b0;
      mem_wb_enable  = 1'b0;
      mem_wb_bubble  = 1'b1;
      st_d           = RUN;
      redir_pc_d     = '0;
    end else if (mem_busy) begin
      // EX is frozen, so a redirect or hazard seen now is still present once memory completes
      pc_enable      = 1'b0;
      if_id_enable   = 1'b0;
      id_exe_enable  = 1'b0;
      exe_mem_enable = 1'b0;
      mem_wb_bubble  = 1'b1;
      stall_evt      = 1'b1;
    end else if (st_q == RUN && ex_redirect_valid) begin
      if_id_flush     = 1'b1;
      id_exe_flush    = 1'b1;
      flush_evt       = 1'b1;
      pc_enable       = ifu_resp_valid;
      pc_sel_redirect = ifu_resp_valid;
      redirect_pc     = ex_redirect_pc;
      st_d            = ifu_resp_valid ? RUN : REDIR_WAIT;
      redir_pc_d      = ifu_resp_valid ? redir_pc_q : ex_redirect_pc;
    end else if (st_q == REDIR_WAIT) begin
      if_id_flush     = 1'b1;
      pc_enable       = ifu_resp_valid;
      pc_sel_redirect = ifu_resp_valid;
      st_d            = ifu_resp_valid ? RUN : REDIR_WAIT;
      redir_pc_d      = ex_redirect_valid ? ex_redirect_pc : redir_pc_q;
    end else if (hazard_detected) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      id_exe_flush = 1'b1;
      stall_evt    = 1'b1;
    end else if (!ifu_resp_valid) begin
      pc_enable   = 1'b0;
      if_id_flush = 1'b1;
      stall_evt   = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= RUN;
      redir_pc_q <= '0;
    end else begin
      st_q       <= st_d;
      redir_pc_q <= redir_pc_d;
    end
  end
`ifdef PIPE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_cnt    <= '0;
    end else begin
      perf_stall_cycles <= perf_stall_cycles + PERF_CNT_W'(stall_evt);
      perf_flush_cnt    <= perf_flush_cnt + PERF_CNT_W'(flush_evt);
    end
  end
`else
  logic unused_evt;
  assign unused_evt = stall_evt ^ flush_evt;
`endif
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed plus randomized check of pipe_ctrl_unit against a rule-table model.
module tb_pipe_ctrl_unit;
  localparam int XLEN = 32;
  localparam int PW   = 4;
  logic clk = 1'b0;
  logic rst = 1'b1, hazard_detected = 1'b0, ex_redirect_valid = 1'b0;
  logic [XLEN-1:0] ex_redirect_pc = '0;
  logic ifu_resp_valid = 1'b1, lsu_req = 1'b0, lsu_resp_valid = 1'b0;
  logic pc_enable, pc_sel_redirect, if_id_enable, if_id_flush, id_exe_enable, id_exe_flush;
  logic exe_mem_enable, mem_wb_enable, mem_wb_bubble;
  logic [XLEN-1:0] redirect_pc;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [PW-1:0] perf_stall_cycles, perf_flush_cnt;
`endif
  int checks = 0, errors = 0;
  bit pend = 1'b0;
  logic [XLEN-1:0] pend_pc = '0;
  logic [PW-1:0] m_stall = '0, m_flush = '0;

  pipe_ctrl_unit #(.XLEN(XLEN), .PERF_CNT_W(PW)) dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
    .ex_redirect_valid(ex_redirect_valid), .ex_redirect_pc(ex_redirect_pc),
    .ifu_resp_valid(ifu_resp_valid), .lsu_req(lsu_req), .lsu_resp_valid(lsu_resp_valid),
    .pc_enable(pc_enable), .pc_sel_redirect(pc_sel_redirect), .redirect_pc(redirect_pc),
    .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .id_exe_enable(id_exe_enable), .id_exe_flush(id_exe_flush),
    .exe_mem_enable(exe_mem_enable), .mem_wb_enable(mem_wb_enable), .mem_wb_bubble(mem_wb_bubble)
`ifdef PIPE_CTRL_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // 0 = reset, otherwise the number of the priority rule that governs this cycle
  function automatic int rule_now();
    if (rst) return 0;
    if (lsu_req && !lsu_resp_valid) return 1;
    if (!pend && ex_redirect_valid) return 2;
    if (pend) return 3;
    if (hazard_detected) return 4;
    if (!ifu_resp_valid) return 5;
    return 6;
  endfunction

  // {pc_en, pc_sel, if_id_en, if_id_flush, id_exe_en, id_exe_flush, exe_mem_en, mem_wb_en, mem_wb_bubble}
  function automatic logic [8:0] exp_vec();
    case (rule_now())
      0: return 9'b000101001;
      1: return 9'b000000011;
      2: return ifu_resp_valid ? 9'b111111110 : 9'b001111110;
      3: return ifu_resp_valid ? 9'b111110110 : 9'b001110110;
      4: return 9'b000011110;
      5: return 9'b001110110;
      default: return 9'b101010110;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] exp_pc();
    if (rst) return '0;
    return pend ? pend_pc : ex_redirect_pc;
  endfunction

  always @(posedge clk) begin : model
    int r;
    r = rule_now();
    if (r == 0) begin
      pend <= 1'b0; pend_pc <= '0; m_stall <= '0; m_flush <= '0;
    end else begin
      if (r == 1 || r == 4 || r == 5) m_stall <= m_stall + 1'b1;
      if (r == 2) begin
        m_flush <= m_flush + 1'b1;
        if (!ifu_resp_valid) begin pend <= 1'b1; pend_pc <= ex_redirect_pc; end
      end
      if (r == 3) begin
        if (ex_redirect_valid) pend_pc <= ex_redirect_pc;
        if (ifu_resp_valid) pend <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [8:0] act, exp;
    act = {pc_enable, pc_sel_redirect, if_id_enable, if_id_flush, id_exe_enable, id_exe_flush,
           exe_mem_enable, mem_wb_enable, mem_wb_bubble};
    exp = exp_vec();
    checks++;
    if (act !== exp) begin errors++; $display("FAIL ctrl_vec t=%0t: got %b expected %b", $time, act, exp); end
    checks++;
    if (redirect_pc !== exp_pc()) begin errors++; $display("FAIL redirect_pc t=%0t: got %h expected %h", $time, redirect_pc, exp_pc()); end
`ifdef PIPE_CTRL_PERF_CNT_EN
    checks++;
    if (perf_stall_cycles !== m_stall) begin errors++; $display("FAIL perf_stall t=%0t: got %0d expected %0d", $time, perf_stall_cycles, m_stall); end
    checks++;
    if (perf_flush_cnt !== m_flush) begin errors++; $display("FAIL perf_flush t=%0t: got %0d expected %0d", $time, perf_flush_cnt, m_flush); end
`endif
  end

  task automatic drive(input logic r, hz, ev, input logic [XLEN-1:0] pc, input logic iv, lq, lr);
    @(posedge clk); #1;
    rst = r; hazard_detected = hz; ex_redirect_valid = ev; ex_redirect_pc = pc;
    ifu_resp_valid = iv; lsu_req = lq; lsu_resp_valid = lr;
    #2;
  endtask

  task automatic lit(input string n, input logic [XLEN-1:0] a, e);
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s: got %h expected %h", n, a, e); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, 1'($urandom_range(1)),
            1'($urandom_range(1)), 1'($urandom_range(1)));
      lit("rst_pc_en", 32'(pc_enable), 0);
      lit("rst_if_id_flush", 32'(if_id_flush), 1);
      lit("rst_mem_wb_bubble", 32'(mem_wb_bubble), 1);
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    lit("idle_pc_en", 32'(pc_enable), 1);
    lit("idle_id_exe_en", 32'(id_exe_enable), 1);
    lit("idle_bubble", 32'(mem_wb_bubble), 0);
    drive(0, 1, 0, 0, 1, 0, 0);
    lit("hz_pc_en", 32'(pc_enable), 0);
    lit("hz_if_id_en", 32'(if_id_enable), 0);
    lit("hz_id_exe_flush", 32'(id_exe_flush), 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    lit("post_hz_id_exe_flush", 32'(id_exe_flush), 0);
    drive(0, 1, 1, 32'h8000_0100, 1, 0, 0);
    lit("redir_sel", 32'(pc_sel_redirect), 1);
    lit("redir_pc", redirect_pc, 32'h8000_0100);
    lit("redir_pc_en", 32'(pc_enable), 1);
    lit("redir_id_exe_flush", 32'(id_exe_flush), 1);
    drive(0, 0, 1, 32'h8000_0200, 0, 0, 0);
    lit("wait0_pc_en", 32'(pc_enable), 0);
    lit("wait0_if_id_flush", 32'(if_id_flush), 1);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'($urandom_range(1)), 0, $urandom, 0, 0, 0);
      lit("wait_pc_en", 32'(pc_enable), 0);
      lit("wait_if_id_flush", 32'(if_id_flush), 1);
      lit("wait_pc", redirect_pc, 32'h8000_0200);
    end
    drive(0, 0, 0, 32'h1234_5678, 1, 0, 0);
    lit("wait_done_sel", 32'(pc_sel_redirect), 1);
    lit("wait_done_pc", redirect_pc, 32'h8000_0200);
    lit("wait_done_pc_en", 32'(pc_enable), 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    lit("after_wait_sel", 32'(pc_sel_redirect), 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 32'h8000_0300, 1, 1, 0);
      lit("mem_pc_en", 32'(pc_enable), 0);
      lit("mem_bubble", 32'(mem_wb_bubble), 1);
      lit("mem_sel", 32'(pc_sel_redirect), 0);
    end
    drive(0, 0, 1, 32'h8000_0300, 1, 1, 1);
    lit("mem_done_sel", 32'(pc_sel_redirect), 1);
    lit("mem_done_pc", redirect_pc, 32'h8000_0300);
    drive(0, 0, 0, 0, 1, 0, 0);
`ifdef PIPE_CTRL_PERF_CNT_EN
    lit("perf_stall_dir", 32'(perf_stall_cycles), 5);
    lit("perf_flush_dir", 32'(perf_flush_cnt), 3);
`endif
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(63) == 0), 1'($urandom_range(3) == 0), 1'($urandom_range(4) == 0),
            $urandom, 1'($urandom_range(3) != 0), 1'($urandom_range(3) == 0), 1'($urandom_range(1)));
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Central stall/flush controller for the 5-stage NPC pipeline; consumes the load-use `hazard_detected` flag, EX branch/jump redirects and IFU/LSU handshakes.
- Drives per-stage enable/flush signals and the PC redirect mux.
- Holds a pending redirect when the IFU is busy, so the redirect is never lost and wrong-path fetches are discarded.

Parameters:
XLEN, 32, PC/redirect address width
PERF_CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
hazard_detected  in  1  load-use hazard on the IF/ID instruction, from the hazard detection unit
ex_redirect_valid  in  1  EX resolved a taken branch/jump this cycle
ex_redirect_pc  in  XLEN  redirect target
ifu_resp_valid  in  1  IFU has the instruction for the current PC (fetch complete)
lsu_req  in  1  MEM stage holds a valid load/store
lsu_resp_valid  in  1  data memory completed the MEM-stage access
pc_enable  out  1  PC register may update
pc_sel_redirect  out  1  PC next = redirect_pc (else PC+4)
redirect_pc  out  XLEN  redirect target to PC mux
if_id_enable  out  1  IF/ID register update
if_id_flush  out  1  IF/ID loads bubble (when enabled)
id_exe_enable  out  1  ID/EX register update
id_exe_flush  out  1  ID/EX loads bubble
exe_mem_enable  out  1  EX/MEM register update
mem_wb_enable  out  1  MEM/WB register update
mem_wb_bubble  out  1  MEM/WB loads bubble

Behaviour:
- State: `st` ∈ {RUN, REDIR_WAIT}, plus `redir_pc_q[XLEN]`. Outputs are combinational from the inputs and the state.
- Reset (rst=1): `st`=RUN, `redir_pc_q`=0.
  - While rst=1, outputs are forced: all *_enable=0; if_id_flush, id_exe_flush, mem_wb_bubble=1; pc_sel_redirect=0; redirect_pc=0.
  - Reset asserted in REDIR_WAIT drops the pending redirect.
- `mem_busy` = lsu_req & ~lsu_resp_valid. Priority, evaluated top-down each cycle:
  1. mem_busy: pc/if_id/id_exe/exe_mem enables=0, mem_wb_enable=1, mem_wb_bubble=1, all other flushes=0. Redirect and hazard are ignored because EX is frozen and its inputs persist. The state is unchanged.
  2. ex_redirect_valid (state RUN): if_id_flush=1, id_exe_flush=1, all stage enables=1. This overrides hazard_detected (the hazarding instruction is wrong-path).
     - If ifu_resp_valid: pc_enable=1, pc_sel_redirect=1, redirect_pc=ex_redirect_pc; stay in RUN.
     - Else: pc_enable=0; `redir_pc_q`<=ex_redirect_pc; `st`<=REDIR_WAIT.
  3. REDIR_WAIT (no mem_busy): redirect_pc=`redir_pc_q`, if_id_flush=1, hazard_detected is ignored, downstream enables=1.
     - If ifu_resp_valid: pc_enable=1, pc_sel_redirect=1, `st`<=RUN.
     - Else pc_enable=0.
     - A new ex_redirect_valid here overwrites `redir_pc_q`. It cannot occur legally (only bubbles are behind the redirect) but must be handled.
  4. hazard_detected: pc_enable=0, if_id_enable=0, id_exe_flush=1, exe_mem/mem_wb enables=1. This is exactly one bubble per hazard cycle.
  5. ~ifu_resp_valid: pc_enable=0, if_id_enable=1, if_id_flush=1 (fetch bubble), rest advance.
  6. Otherwise all enables=1, all flushes/bubble=0, pc_sel_redirect=0.
- Whenever pc_sel_redirect=0, redirect_pc=ex_redirect_pc in RUN and `redir_pc_q` in REDIR_WAIT.
- Latency: redirect takes effect on PC the same cycle if fetch is ready. Otherwise it takes effect in the cycle ifu_resp_valid rises, with zero added cycles.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- When defined, adds these outputs:
  - `perf_stall_cycles[PERF_CNT_W]`: +1 in each cycle where rule 1, 4 or 5 applies.
  - `perf_flush_cnt[PERF_CNT_W]`: +1 per accepted redirect, i.e. rule 2 firing; REDIR_WAIT cycles do not count again.
- Both counters reset to 0 on rst, wrap modulo 2^PERF_CNT_W, and are never stalled.
- When the macro is undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 for 3 cycles with random inputs -> all enables 0, flush/bubble 1; after release with idle inputs (ifu_resp_valid=1, others 0) -> all enables 1, flushes 0.
- Load-use: hazard_detected=1 for one cycle -> pc_enable=0, if_id_enable=0, id_exe_flush=1 that cycle only; next cycle normal.
- Redirect, fetch ready: ex_redirect_valid=1, ex_redirect_pc=0x80000100, hazard_detected=1 -> pc_sel_redirect=1, redirect_pc=0x80000100, if_id_flush=id_exe_flush=1, pc_enable=1.
- Redirect, fetch busy: redirect to 0x80000200 with ifu_resp_valid=0 for 3 cycles -> REDIR_WAIT with pc_enable=0 and if_id_flush=1 for 3 cycles; on the 4th cycle (ifu_resp_valid=1) pc_sel_redirect=1, redirect_pc=0x80000200, then RUN.
- Memory stall: lsu_req=1, lsu_resp_valid=0 for 4 cycles while ex_redirect_valid=1 -> 4 cycles of frozen front-end with mem_wb_bubble=1 and no redirect; the redirect applies in the cycle lsu_resp_valid=1.
- PIPE_CTRL_PERF_CNT_EN: the above sequence -> perf_stall_cycles and perf_flush_cnt match cycle counts exactly; force the counter to 2^PERF_CNT_W-1 and verify it wraps to 0.
